stepdown_state_sequencer: RTL and testbench

Sequences the step-down converter core through its operating states and drives the one-hot `tstate[4:0]` bus consumed by the core-state decode logic. It owns power-up pre-charge, the soft-start ramp code, regulation, fault hold-off with bounded auto-retry, and output discharge. The block sits in the stepdown core-state partition, between the enable/supervisor inputs and the analog core control nets.

---
 rtl/stepdown_seq_pkg.sv | 36 +++
 rtl/stepdown_state_sequencer_if.sv | 33 +++
 rtl/stepdown_seq_timer.sv | 40 ++++
 rtl/stepdown_state_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_stepdown_state_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stepdown_seq_pkg.sv
// Shared types and constants for the step-down converter state sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stepdown_seq_pkg;

    // Operating states of the converter core.
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PRECHG = 3'd1,
        ST_SOFTST = 3'd2,
        ST_REG    = 3'd3,
        ST_FAULT  = 3'd4,
        ST_DISCH  = 3'd5
    } seq_state_e;

    // Bit positions in the one-hot tstate bus; OFF is all zero.
    localparam int TS_PRECHG = 0;
    localparam int TS_SOFTST = 1;
    localparam int TS_REG    = 2;
    localparam int TS_FAULT  = 3;
    localparam int TS_DISCH  = 4;
    localparam int TS_W      = 5;

    // Retry counter holds 0..7.
    localparam int RETRY_W = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold a dwell of max_cyc clocks loaded as max_cyc-1.
    function automatic int tmr_width(input int max_cyc);
        return (max_cyc > 2) ? $clog2(max_cyc) : 1;
    endfunction

endpackage

// File: rtl/stepdown_state_sequencer_if.sv
// Supervisor inputs and core-control outputs of the state sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels valid every clock.
interface stepdown_state_sequencer_if #(
    parameter int SS_W = 6
);
    import stepdown_seq_pkg::*;

    logic               en;
    logic               uv_ok;
    logic               ocp;
    logic               ovp;
    logic               pg_cmp;
    logic [TS_W-1:0]    tstate;
    logic [SS_W-1:0]    ss_code;
    logic               pgood;
    logic               fault;
    logic               lockout;
    logic [RETRY_W-1:0] retry_cnt;

    // Supervisor / analog side: drives enables and flags, observes state.
    modport master (
        output en, uv_ok, ocp, ovp, pg_cmp,
        input  tstate, ss_code, pgood, fault, lockout, retry_cnt
    );

    // Sequencer side.
    modport slave (
        input  en, uv_ok, ocp, ovp, pg_cmp,
        output tstate, ss_code, pgood, fault, lockout, retry_cnt
    );

endinterface

// File: rtl/stepdown_seq_timer.sv
// Loadable down-counter shared by every dwell, the soft-start prescale and timeout.
// Latency: loaded value visible the clock after load; expired is combinational on the count.
// Backpressure: none; counts every clock until it reaches zero, then holds.
module stepdown_seq_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Load wins over counting; the count parks at zero.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign expired = (value_q == '0);

endmodule

// File: rtl/stepdown_state_sequencer.sv
// Sequences the step-down core through OFF/PRECHG/SOFTST/REG/FAULT/DISCH and drives tstate.
// Latency: every output is registered; it reflects inputs sampled on the previous edge.
// Backpressure: none; enable/fault inputs are levels evaluated every clock.
module stepdown_state_sequencer
    import stepdown_seq_pkg::*;
#(
    parameter int PRECHG_CYC = 256,
    parameter int SS_STEPS   = 64,
    parameter int SS_DIV     = 16,
    parameter int SS_TMO     = 32,
    parameter int RETRY_WAIT = 1024,
    parameter int RETRY_MAX  = 3,
    parameter int DISCH_CYC  = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    stepdown_state_sequencer_if.slave bus
);

    localparam int SS_W   = $clog2(SS_STEPS);
    localparam int TMR_W  = tmr_width(max_int(max_int(max_int(PRECHG_CYC, SS_DIV),
                                                      max_int(SS_TMO, RETRY_WAIT)),
                                              DISCH_CYC));

    // A dwell of N clocks loads N-1 so the state bit is high for exactly N cycles.
    localparam logic [TMR_W-1:0] LD_PRECHG = TMR_W'(PRECHG_CYC - 1);
    localparam logic [TMR_W-1:0] LD_SS_DIV = TMR_W'(SS_DIV - 1);
    localparam logic [TMR_W-1:0] LD_SS_TMO = TMR_W'(SS_TMO - 1);
    localparam logic [TMR_W-1:0] LD_RETRY  = TMR_W'(RETRY_WAIT - 1);
    localparam logic [TMR_W-1:0] LD_DISCH  = TMR_W'(DISCH_CYC - 1);

    localparam logic [SS_W-1:0]    SS_MAX     = SS_W'(SS_STEPS - 1);
    localparam logic [SS_W-1:0]    SS_PRE_SAT = SS_W'(SS_STEPS - 2);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(RETRY_MAX);

    seq_state_e         state_q, state_d;
    logic [SS_W-1:0]    ss_q, ss_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_q, lock_d;
    logic [TS_W-1:0]    tstate_q, tstate_d;
    logic               pgood_q, pgood_d;
    logic               fault_q, fault_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic [TMR_W-1:0]   tmr_value;
    logic               tmr_expired;
    logic               tmr_value_unused;

    logic dis_req;
    logic flt_req;
    logic ss_sat;

    assign dis_req = !bus.en || !bus.uv_ok;
    assign flt_req = bus.ocp || bus.ovp;
    assign ss_sat  = (ss_q == SS_MAX);

    // Only expiry drives decisions; the remaining count is not needed here.
    assign tmr_value_unused = ^tmr_value;

    stepdown_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .expired  (tmr_expired)
    );

    // Next state with priority disable > fault > normal progression, plus output decode.
    always_comb begin
        state_d  = state_q;
        ss_d     = ss_q;
        retry_d  = retry_q;
        lock_d   = lock_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_OFF: begin
                if (!dis_req) begin
                    state_d  = ST_PRECHG;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PRECHG;
                end
            end
            // Overcurrent/overvoltage are not meaningful while pre-charging.
            ST_PRECHG: begin
                if (dis_req) begin
                    state_d  = ST_DISCH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_DISCH;
                end else if (tmr_expired) begin
                    state_d  = ST_SOFTST;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SS_DIV;
                end
            end
            // Timer is the step prescaler until the ramp saturates, then the pg timeout.
            ST_SOFTST: begin
                if (dis_req) begin
                    state_d  = ST_DISCH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_DISCH;
                end else if (flt_req) begin
                    state_d  = ST_FAULT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RETRY;
                end else if (ss_sat) begin
                    if (bus.pg_cmp) begin
                        state_d = ST_REG;
                    end else if (tmr_expired) begin
                        state_d  = ST_FAULT;
                        tmr_load = 1'b1;
                        tmr_val  = LD_RETRY;
                    end
                end else if (tmr_expired) begin
                    ss_d     = ss_q + 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = (ss_q == SS_PRE_SAT) ? LD_SS_TMO : LD_SS_DIV;
                end
            end
            // Losing pg_cmp in regulation is tolerated; only faults and disable leave.
            ST_REG: begin
                if (dis_req) begin
                    state_d  = ST_DISCH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_DISCH;
                end else if (flt_req) begin
                    state_d  = ST_FAULT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RETRY;
                end
            end
            // After the hold-off either retry from pre-charge or latch lockout and wait.
            ST_FAULT: begin
                if (dis_req) begin
                    state_d  = ST_DISCH;
                    tmr_load = 1'b1;
                    tmr_val  = LD_DISCH;
                end else if (tmr_expired) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d  = retry_q + 1'b1;
                        state_d  = ST_PRECHG;
                        tmr_load = 1'b1;
                        tmr_val  = LD_PRECHG;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            // Discharge always runs to completion, whatever the enable does.
            ST_DISCH: begin
                if (tmr_expired) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // OFF gives the retry budget back.
        if (state_d == ST_OFF) begin
            retry_d = '0;
            lock_d  = 1'b0;
        end

        // The reference code is only live while ramping or regulating.
        if (!((state_d == ST_SOFTST) || (state_d == ST_REG))) begin
            ss_d = '0;
        end

        tstate_d = '0;
        case (state_d)
            ST_PRECHG: tstate_d[TS_PRECHG] = 1'b1;
            ST_SOFTST: tstate_d[TS_SOFTST] = 1'b1;
            ST_REG:    tstate_d[TS_REG]    = 1'b1;
            ST_FAULT:  tstate_d[TS_FAULT]  = 1'b1;
            ST_DISCH:  tstate_d[TS_DISCH]  = 1'b1;
            default:   tstate_d            = '0;
        endcase
        pgood_d = (state_d == ST_REG);
        fault_d = (state_d == ST_FAULT);
    end

    // State and registered outputs; reset drops everything at once with no discharge pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            ss_q     <= '0;
            retry_q  <= '0;
            lock_q   <= 1'b0;
            tstate_q <= '0;
            pgood_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ss_q     <= ss_d;
            retry_q  <= retry_d;
            lock_q   <= lock_d;
            tstate_q <= tstate_d;
            pgood_q  <= pgood_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.tstate    = tstate_q;
    assign bus.ss_code   = ss_q;
    assign bus.pgood     = pgood_q;
    assign bus.fault     = fault_q;
    assign bus.lockout   = lock_q;
    assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_stepdown_state_sequencer.sv
// Directed bench for the state sequencer: cycle-age model compared every clock plus literal checkpoints.
// Latency: n/a.
// Backpressure: n/a.
module tb_stepdown_state_sequencer;

    localparam int PRECHG_CYC = 256;
    localparam int SS_STEPS   = 64;
    localparam int SS_DIV     = 16;
    localparam int SS_TMO     = 32;
    localparam int RETRY_WAIT = 1024;
    localparam int RETRY_MAX  = 3;
    localparam int DISCH_CYC  = 128;
    localparam int SS_W       = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stepdown_state_sequencer_if #(.SS_W(SS_W)) bus ();

    stepdown_state_sequencer #(
        .PRECHG_CYC (PRECHG_CYC),
        .SS_STEPS   (SS_STEPS),
        .SS_DIV     (SS_DIV),
        .SS_TMO     (SS_TMO),
        .RETRY_WAIT (RETRY_WAIT),
        .RETRY_MAX  (RETRY_MAX),
        .DISCH_CYC  (DISCH_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model: phase + cycles spent in phase ----------------
    localparam int P_OFF = 0, P_PRE = 1, P_SS = 2, P_REG = 3, P_FLT = 4, P_DIS = 5;
    localparam int SAT_AGE = (SS_STEPS - 1) * SS_DIV;

    int m_ph, m_age, m_retry, nph;
    bit m_lock, dis, flt;

    initial begin
        m_ph = P_OFF; m_age = 0; m_retry = 0; m_lock = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = P_OFF; m_age = 0; m_retry = 0; m_lock = 0;
            end else begin
                dis = !bus.en || !bus.uv_ok;
                flt = bus.ocp || bus.ovp;
                nph = m_ph;
                case (m_ph)
                    P_OFF: if (!dis) nph = P_PRE;
                    P_PRE: if (dis) nph = P_DIS; else if (m_age == PRECHG_CYC - 1) nph = P_SS;
                    P_SS: begin
                        if (dis) nph = P_DIS;
                        else if (flt) nph = P_FLT;
                        else if (m_age >= SAT_AGE && bus.pg_cmp) nph = P_REG;
                        else if (m_age == SAT_AGE + SS_TMO - 1) nph = P_FLT;
                    end
                    P_REG: if (dis) nph = P_DIS; else if (flt) nph = P_FLT;
                    P_FLT: begin
                        if (dis) nph = P_DIS;
                        else if (m_age >= RETRY_WAIT - 1) begin
                            if (m_retry < RETRY_MAX) begin m_retry++; nph = P_PRE; end
                            else m_lock = 1;
                        end
                    end
                    P_DIS: if (m_age == DISCH_CYC - 1) nph = P_OFF;
                    default: nph = P_OFF;
                endcase
                if (nph == P_OFF && m_ph != P_OFF) begin m_retry = 0; m_lock = 0; end
                m_age = (nph == m_ph) ? m_age + 1 : 0;
                m_ph  = nph;
            end
        end
    end

    function automatic int model_vec();
        int ts, ss;
        ts = (m_ph == P_OFF) ? 0 : (1 << (m_ph - 1));
        ss = 0;
        if (m_ph == P_SS)  ss = (m_age / SS_DIV > SS_STEPS - 1) ? SS_STEPS - 1 : m_age / SS_DIV;
        if (m_ph == P_REG) ss = SS_STEPS - 1;
        return (ts << 12) | (ss << 6) | (int'(m_ph == P_REG) << 5) | (int'(m_ph == P_FLT) << 4)
               | (int'(m_lock) << 3) | m_retry;
    endfunction

    function automatic int dut_vec();
        int v;
        v = {15'd0, bus.tstate, bus.ss_code, bus.pgood, bus.fault, bus.lockout, bus.retry_cnt};
        return v;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) chk("model", dut_vec(), model_vec());
        end
    end

    // ---------------- helpers ----------------
    task automatic count_in(input logic [4:0] v, output int n);
        n = 0;
        while (bus.tstate == v && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_for_ts(input logic [4:0] v, input string nm);
        int n = 0;
        while (bus.tstate != v && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(bus.tstate), int'(v));
    endtask

    task automatic ramp_len(output int n);
        n = 0;
        while (bus.ss_code != 6'd63 && bus.tstate == 5'b00010 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n, entries;
        bit prev;
        bus.en = 0; bus.uv_ok = 0; bus.ocp = 0; bus.ovp = 0; bus.pg_cmp = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outputs", dut_vec(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal start-up
        bus.en = 1; bus.uv_ok = 1;
        @(negedge clk);
        count_in(5'b00001, n);
        chk("prechg_len", n, 256);
        chk("softst_entry", int'(bus.tstate), 2);
        chk("ss_start", int'(bus.ss_code), 0);
        ramp_len(n);
        chk("ramp_len", n, 1008);
        bus.pg_cmp = 1;
        @(negedge clk);
        chk("reg_tstate", int'(bus.tstate), 4);
        chk("reg_pgood", int'(bus.pgood), 1);
        chk("reg_ss", int'(bus.ss_code), 63);

        // pg_cmp dropping in REG is ignored
        bus.pg_cmp = 0;
        repeat (3) @(negedge clk);
        chk("reg_pg_drop", int'(bus.tstate), 4);

        // OCP in REG
        bus.ocp = 1;
        @(negedge clk);
        bus.ocp = 0;
        chk("ocp_tstate", int'(bus.tstate), 8);
        chk("ocp_fault", int'(bus.fault), 1);
        chk("ocp_ss", int'(bus.ss_code), 0);
        count_in(5'b01000, n);
        chk("fault_len", n, 1024);
        chk("retry1_cnt", int'(bus.retry_cnt), 1);
        chk("retry1_tstate", int'(bus.tstate), 1);

        // Soft-start timeout with pg_cmp held low
        wait_for_ts(5'b00010, "tmo_softst");
        ramp_len(n);
        chk("tmo_ramp_len", n, 1008);
        count_in(5'b00010, n);
        chk("tmo_len", n, 32);
        chk("tmo_fault", int'(bus.tstate), 8);
        chk("tmo_retry", int'(bus.retry_cnt), 1);

        // Disable and fault together during SOFTST: DISCH wins
        wait_for_ts(5'b00001, "retry2_prechg");
        chk("retry2_cnt", int'(bus.retry_cnt), 2);
        wait_for_ts(5'b00010, "sim_softst");
        repeat (5) @(negedge clk);
        bus.uv_ok = 0; bus.ocp = 1;
        @(negedge clk);
        bus.ocp = 0;
        chk("sim_disch", int'(bus.tstate), 16);
        count_in(5'b10000, n);
        chk("disch_len", n, 128);
        chk("off_tstate", int'(bus.tstate), 0);
        chk("off_retry_clr", int'(bus.retry_cnt), 0);

        // Persistent OCP to lockout
        bus.uv_ok = 1; bus.ocp = 1;
        entries = 0; prev = 0; n = 0;
        while (!bus.lockout && n < 20000) begin
            @(negedge clk);
            n++;
            if (bus.tstate == 5'b01000 && !prev) entries++;
            prev = (bus.tstate == 5'b01000);
        end
        chk("lock_entries", entries, 4);
        chk("lock_flag", int'(bus.lockout), 1);
        chk("lock_retry", int'(bus.retry_cnt), 3);
        repeat (50) @(negedge clk);
        chk("lock_stay", int'(bus.tstate), 8);
        bus.en = 0;
        @(negedge clk);
        bus.ocp = 0;
        chk("lock_disch", int'(bus.tstate), 16);
        chk("lock_sticky", int'(bus.lockout), 1);
        count_in(5'b10000, n);
        chk("lock_disch_len", n, 128);
        chk("lock_off_tstate", int'(bus.tstate), 0);
        chk("lock_off_retry", int'(bus.retry_cnt), 0);
        chk("lock_off_lockout", int'(bus.lockout), 0);

        // Asynchronous reset mid-REG
        bus.en = 1; bus.uv_ok = 1; bus.pg_cmp = 1;
        wait_for_ts(5'b00100, "rst_reg");
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", dut_vec(), 0);
        bus.en = 0; bus.pg_cmp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_off", int'(bus.tstate), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
